// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: register IDs, RNONE and instruction codes.
package y86_pkg;

    localparam int unsigned WORD_W   = 64;
    localparam int unsigned REG_ID_W = 4;
    localparam int unsigned NUM_REGS = 15;

    localparam logic [REG_ID_W-1:0] RNONE = 4'hF;

    localparam logic [REG_ID_W-1:0] RAX = 4'h0;
    localparam logic [REG_ID_W-1:0] RCX = 4'h1;
    localparam logic [REG_ID_W-1:0] RDX = 4'h2;
    localparam logic [REG_ID_W-1:0] RBX = 4'h3;
    localparam logic [REG_ID_W-1:0] RSP = 4'h4;
    localparam logic [REG_ID_W-1:0] RBP = 4'h5;
    localparam logic [REG_ID_W-1:0] RSI = 4'h6;
    localparam logic [REG_ID_W-1:0] RDI = 4'h7;
    localparam logic [REG_ID_W-1:0] R8  = 4'h8;
    localparam logic [REG_ID_W-1:0] R9  = 4'h9;
    localparam logic [REG_ID_W-1:0] R10 = 4'hA;
    localparam logic [REG_ID_W-1:0] R11 = 4'hB;
    localparam logic [REG_ID_W-1:0] R12 = 4'hC;
    localparam logic [REG_ID_W-1:0] R13 = 4'hD;
    localparam logic [REG_ID_W-1:0] R14 = 4'hE;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

endpackage

// File: rtl/y86_pend_counter.sv
// Per-register count of in-flight writes with floor-at-zero and saturation lookahead.
module y86_pend_counter
    import y86_pkg::*;
#(
    parameter int unsigned MAX_PEND = 3,
    parameter int unsigned CNT_W    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       inc,
    input  logic             inc_en,
    input  logic [1:0]       dec,
    output logic [CNT_W-1:0] cnt,
    output logic             sat,
    output logic             underflow
);

    localparam int unsigned PW = CNT_W + 2;

    logic signed [PW-1:0] after_dec;
    logic signed [PW-1:0] after_inc;
    logic [CNT_W-1:0]     cnt_nxt;

    // Signed net update; sat looks ahead at the booking, underflow flags over-retire.
    always_comb begin
        after_dec = $signed(PW'(cnt)) - $signed(PW'(dec));
        after_inc = after_dec + $signed(PW'(inc));
        sat       = after_inc > $signed(PW'(MAX_PEND));
        underflow = after_dec[PW-1];
        cnt_nxt   = cnt;
        if (inc_en) begin
            cnt_nxt = after_inc[PW-1] ? '0 : CNT_W'(after_inc);
        end else begin
            cnt_nxt = after_dec[PW-1] ? '0 : CNT_W'(after_dec);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/y86_regfile_sb.sv
// Y86-64 register file: 2 read / 2 write ports, write-through bypass, pending-write scoreboard.
module y86_regfile_sb
    import y86_pkg::*;
#(
    parameter int unsigned WIDTH      = WORD_W,
    parameter int unsigned NREGS      = NUM_REGS,
    parameter int unsigned RID_W      = REG_ID_W,
    parameter int unsigned RSP_ID     = int'(RSP),
    parameter int unsigned STACK_INIT = 256,
    parameter int unsigned MAX_PEND   = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [RID_W-1:0]       src_a,
    input  logic [RID_W-1:0]       src_b,
    output logic [WIDTH-1:0]       val_a,
    output logic [WIDTH-1:0]       val_b,
    output logic                   haz_a,
    output logic                   haz_b,
    input  logic                   iss_valid,
    input  logic [RID_W-1:0]       iss_dst_e,
    input  logic [RID_W-1:0]       iss_dst_m,
    output logic                   iss_ready,
    input  logic                   wb_valid,
    input  logic [RID_W-1:0]       wb_dst_e,
    input  logic [RID_W-1:0]       wb_dst_m,
    input  logic                   wb_cnd,
    input  logic [WIDTH-1:0]       val_e,
    input  logic [WIDTH-1:0]       val_m,
    output logic [NREGS*WIDTH-1:0] regs_flat,
    output logic                   err
);

    localparam int unsigned CNT_W = $clog2(MAX_PEND + 1);
    localparam int unsigned PW    = CNT_W + 2;

    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] sat_v;
    logic [NREGS-1:0] under_v;
    logic [NREGS-1:0] pend_v;
    logic             accept;
    logic             hit_a;
    logic             hit_b;

    assign iss_ready = ~|sat_v;
    assign accept    = iss_valid & iss_ready;

    // One scoreboard counter per architectural register; IDs >= NREGS never match.
    for (genvar g = 0; g < NREGS; g++) begin : g_pend
        logic [1:0]       inc;
        logic [1:0]       dec;
        logic [CNT_W-1:0] cnt;

        assign inc = 2'(iss_dst_e == RID_W'(g)) + 2'(iss_dst_m == RID_W'(g));
        assign dec = wb_valid ? 2'(wb_dst_e == RID_W'(g)) + 2'(wb_dst_m == RID_W'(g)) : 2'd0;

        y86_pend_counter #(
            .MAX_PEND (MAX_PEND),
            .CNT_W    (CNT_W)
        ) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (inc),
            .inc_en    (accept),
            .dec       (dec),
            .cnt       (cnt),
            .sat       (sat_v[g]),
            .underflow (under_v[g])
        );

        // Still pending once this cycle's retirements are taken out.
        assign pend_v[g] = PW'(cnt) > PW'(dec);
        assign regs_flat[g*WIDTH +: WIDTH] = regs[g];
    end

    // Register array; M port overrides E on the same destination (popq %rsp).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs[r] <= (r == RSP_ID) ? WIDTH'(STACK_INIT) : '0;
            end
        end else begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                if (wb_valid && wb_dst_m == RID_W'(r)) begin
                    regs[r] <= val_m;
                end else if (wb_valid && wb_cnd && wb_dst_e == RID_W'(r)) begin
                    regs[r] <= val_e;
                end
            end
        end
    end

    // Read ports with write-through bypass and hazard lookup.
    always_comb begin
        val_a = '0;
        val_b = '0;
        haz_a = 1'b0;
        haz_b = 1'b0;
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            if (src_a == RID_W'(r)) begin
                val_a = regs[r];
                haz_a = pend_v[r];
                hit_a = 1'b1;
            end
            if (src_b == RID_W'(r)) begin
                val_b = regs[r];
                haz_b = pend_v[r];
                hit_b = 1'b1;
            end
        end
        if (hit_a && wb_valid && src_a == wb_dst_m) begin
            val_a = val_m;
        end else if (hit_a && wb_valid && wb_cnd && src_a == wb_dst_e) begin
            val_a = val_e;
        end
        if (hit_b && wb_valid && src_b == wb_dst_m) begin
            val_b = val_m;
        end else if (hit_b && wb_valid && wb_cnd && src_b == wb_dst_e) begin
            val_b = val_e;
        end
    end

    // Sticky protocol error: refused issue or over-retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if ((iss_valid && !iss_ready) || (|under_v)) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_y86_regfile_sb.sv
// Directed plus randomized bench for y86_regfile_sb against a behavioural model.
module tb_y86_regfile_sb;

    localparam int NR = 15;
    localparam int MP = 3;
    localparam logic [3:0] NONE = 4'hF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    src_a, src_b, iss_dst_e, iss_dst_m, wb_dst_e, wb_dst_m;
    logic [63:0]   val_a, val_b, val_e, val_m;
    logic          haz_a, haz_b, iss_valid, iss_ready, wb_valid, wb_cnd, err;
    logic [959:0]  regs_flat;

    logic [63:0]   m_regs [NR];
    int            m_cnt  [NR];
    bit            m_err;
    int            checks   = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    y86_regfile_sb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_a     (src_a),
        .src_b     (src_b),
        .val_a     (val_a),
        .val_b     (val_b),
        .haz_a     (haz_a),
        .haz_b     (haz_b),
        .iss_valid (iss_valid),
        .iss_dst_e (iss_dst_e),
        .iss_dst_m (iss_dst_m),
        .iss_ready (iss_ready),
        .wb_valid  (wb_valid),
        .wb_dst_e  (wb_dst_e),
        .wb_dst_m  (wb_dst_m),
        .wb_cnd    (wb_cnd),
        .val_e     (val_e),
        .val_m     (val_m),
        .regs_flat (regs_flat),
        .err       (err)
    );

    function automatic int n_match(input logic [3:0] a, input logic [3:0] b, input int r);
        return int'(int'(a) == r) + int'(int'(b) == r);
    endfunction

    function automatic int dec_of(input int r);
        return wb_valid ? n_match(wb_dst_e, wb_dst_m, r) : 0;
    endfunction

    function automatic logic [63:0] exp_read(input logic [3:0] s);
        if (int'(s) >= NR) return 64'd0;
        if (wb_valid && s == wb_dst_m) return val_m;
        if (wb_valid && wb_cnd && s == wb_dst_e) return val_e;
        return m_regs[s];
    endfunction

    function automatic logic exp_haz(input logic [3:0] s);
        if (int'(s) >= NR) return 1'b0;
        return (m_cnt[s] - dec_of(int'(s))) > 0;
    endfunction

    function automatic logic exp_ready();
        for (int r = 0; r < NR; r++) begin
            if (m_cnt[r] - dec_of(r) + n_match(iss_dst_e, iss_dst_m, r) > MP) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_regs[r] = (r == 4) ? 64'd256 : 64'd0;
            m_cnt[r]  = 0;
        end
        m_err = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":val_a"}, val_a, exp_read(src_a));
        chk({tag, ":val_b"}, val_b, exp_read(src_b));
        chk({tag, ":haz_a"}, 64'(haz_a), 64'(exp_haz(src_a)));
        chk({tag, ":haz_b"}, 64'(haz_b), 64'(exp_haz(src_b)));
        chk({tag, ":iss_ready"}, 64'(iss_ready), 64'(exp_ready()));
        chk({tag, ":err"}, 64'(err), 64'(m_err));
        for (int r = 0; r < NR; r++) begin
            chk($sformatf("%s:reg%0d", tag, r), regs_flat[r*64 +: 64], m_regs[r]);
        end
    endtask

    // Advance the model by the clock edge using the currently driven inputs.
    task automatic tick();
        int          nc [NR];
        logic [63:0] nr [NR];
        bit          ne;
        bit          acc;
        int          v;
        acc = iss_valid && exp_ready();
        ne  = m_err || (iss_valid && !exp_ready());
        for (int r = 0; r < NR; r++) begin
            if (dec_of(r) > m_cnt[r]) ne = 1'b1;
            v = m_cnt[r] + (acc ? n_match(iss_dst_e, iss_dst_m, r) : 0) - dec_of(r);
            nc[r] = (v < 0) ? 0 : v;
            nr[r] = m_regs[r];
        end
        if (wb_valid) begin
            if (wb_cnd && int'(wb_dst_e) < NR) nr[wb_dst_e] = val_e;
            if (int'(wb_dst_m) < NR) nr[wb_dst_m] = val_m;
        end
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_regs = nr;
            m_cnt  = nc;
            m_err  = ne;
        end
        @(negedge clk);
    endtask

    task automatic step(input string tag);
        #1;
        check_all(tag);
        tick();
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_dst_e = NONE; iss_dst_m = NONE;
        wb_valid  = 1'b0; wb_dst_e  = NONE; wb_dst_m  = NONE; wb_cnd = 1'b0;
        val_e = 64'd0; val_m = 64'd0;
    endtask

    task automatic issue(input logic [3:0] e, input logic [3:0] m);
        idle();
        iss_valid = 1'b1; iss_dst_e = e; iss_dst_m = m;
    endtask

    task automatic retire(input logic [3:0] e, input logic [3:0] m, input logic c,
                          input logic [63:0] ve, input logic [63:0] vm);
        idle();
        wb_valid = 1'b1; wb_dst_e = e; wb_dst_m = m; wb_cnd = c; val_e = ve; val_m = vm;
    endtask

    task automatic rand_step();
        int r;
        src_a = 4'($urandom_range(0, 15));
        src_b = 4'($urandom_range(0, 15));
        wb_valid = 1'($urandom_range(0, 1));
        wb_cnd   = 1'($urandom_range(0, 1));
        val_e    = {$urandom, $urandom};
        val_m    = {$urandom, $urandom};
        r = int'($urandom_range(0, 15));
        wb_dst_e = (r < NR && m_cnt[r] > 0) ? 4'(r) : NONE;
        r = int'($urandom_range(0, 15));
        wb_dst_m = (r < NR && m_cnt[r] > int'(int'(wb_dst_e) == r)) ? 4'(r) : NONE;
        iss_dst_e = 4'($urandom_range(0, 15));
        iss_dst_m = 4'($urandom_range(0, 15));
        iss_valid = 1'($urandom_range(0, 1));
        if (iss_valid && !exp_ready() && $urandom_range(0, 9) != 0) iss_valid = 1'b0;
        step("rand");
    endtask

    initial begin
        rst_n = 1'b0;
        src_a = 4'd0; src_b = 4'd4;
        idle();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check_all("reset");
        chk("reset_rsp", regs_flat[4*64 +: 64], 64'd256);
        rst_n = 1'b1;
        @(negedge clk);

        // Write-through bypass on E port.
        issue(4'd3, NONE);
        step("book3");
        retire(4'd3, NONE, 1'b1, 64'h55, 64'd0);
        src_a = 4'd3;
        #1;
        chk("bypass_val_a", val_a, 64'h55);
        step("bypass");
        idle();
        step("bypass_after");
        chk("reg3_written", regs_flat[3*64 +: 64], 64'h55);

        // Hazard on a pending write, cleared by retirement.
        issue(4'd2, NONE);
        step("book2");
        idle();
        src_b = 4'd2;
        #1;
        chk("haz_b_pending", 64'(haz_b), 64'd1);
        step("haz_pending");
        retire(4'd2, NONE, 1'b1, 64'hAB, 64'd0);
        #1;
        chk("haz_b_retire", 64'(haz_b), 64'd0);
        chk("val_b_retire", val_b, 64'hAB);
        step("haz_retire");
        idle();
        #1;
        chk("haz_b_after", 64'(haz_b), 64'd0);
        step("haz_after");

        // popq %rsp: both ports target RSP, M data wins.
        issue(4'd4, 4'd4);
        step("popq_book");
        retire(4'd4, 4'd4, 1'b1, 64'h108, 64'h77);
        src_a = 4'd4;
        #1;
        chk("popq_bypass", val_a, 64'h77);
        chk("popq_haz", 64'(haz_a), 64'd0);
        step("popq_retire");
        idle();
        step("popq_after");
        chk("popq_reg4", regs_flat[4*64 +: 64], 64'h77);

        // cmov not taken: retire without writing.
        issue(4'd5, NONE);
        step("cmov_book");
        retire(4'd5, NONE, 1'b0, 64'd9, 64'd0);
        src_a = 4'd5;
        step("cmov_retire");
        idle();
        step("cmov_after");
        chk("cmov_reg5", regs_flat[5*64 +: 64], 64'd0);
        chk("cmov_err", 64'(err), 64'd0);
        chk("cmov_haz", 64'(haz_a), 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) rand_step();

        // Asynchronous reset in the middle of traffic.
        issue(4'd6, 4'd6);
        step("pre_reset");
        src_a = 4'd6; src_b = 4'd4;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midreset_reg4", regs_flat[4*64 +: 64], 64'd256);
        chk("midreset_haz_a", 64'(haz_a), 64'd0);
        chk("midreset_ready", 64'(iss_ready), 64'd1);
        step("midreset");
        rst_n = 1'b1;
        idle();
        step("post_reset");

        // Saturation: fourth booking of r1 is refused and flags err.
        for (int i = 0; i < 3; i++) begin
            issue(4'd1, NONE);
            step("sat_book");
        end
        issue(4'd1, NONE);
        #1;
        chk("sat_ready", 64'(iss_ready), 64'd0);
        step("sat_force");
        idle();
        step("sat_after");
        chk("sat_err", 64'(err), 64'd1);

        // Underflow: retiring unbooked r7 flags err, still writes, count stays 0.
        rst_n = 1'b0;
        model_reset();
        step("reset2");
        rst_n = 1'b1;
        idle();
        step("reset2_rel");
        retire(4'd7, NONE, 1'b1, 64'h7, 64'd0);
        step("under_retire");
        idle();
        src_a = 4'd7;
        step("under_after");
        chk("under_err", 64'(err), 64'd1);
        chk("under_haz", 64'(haz_a), 64'd0);
        chk("under_reg7", regs_flat[7*64 +: 64], 64'h7);
        issue(4'd7, NONE);
        step("under_rebook");
        idle();
        #1;
        chk("under_cnt1", 64'(haz_a), 64'd1);
        step("under_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
